// File: rtl/imem_port.sv
// imem_port: bridge between the fetch stage req/gnt/rvalid/err protocol and a
// single-port synchronous instruction SRAM. Responses return in order at a
// fixed MEM_LATENCY after grant. At most MAX_OUTSTANDING requests are in
// flight at once. A flush discards responses that are already in flight.
// Optional build macro IMEM_ERR_CHECK_EN: a misaligned or out-of-range
// request is granted but does not touch the SRAM. It then retires with
// err=1 and rdata=0. Without the macro, bits [1:0] of the address are
// ignored, the word address wraps, and err is always 0.
module imem_port #(
    parameter int          ADDR_WIDTH      = 12,
    parameter int          MEM_LATENCY     = 1,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] BASE_ADDR       = 32'h0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  instr_req_i,
    input  logic [31:0]           instr_addr_i,
    output logic                  instr_gnt_o,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    output logic                  instr_err_o,
    input  logic                  flush_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [31:0]           mem_rdata_i
);

    localparam logic [2:0] MAX_CNT = 3'(MAX_OUTSTANDING);

    logic [31:0]           offset_s;
    logic [ADDR_WIDTH-1:0] word_addr_s;
    logic                  bad_s;
    logic                  retire_s;
    logic                  gnt_s;
    logic                  rvalid_s;
    logic [31:0]           last_data_s;

    logic [2:0]             cnt_r;
    logic [ADDR_WIDTH-1:0]  mem_addr_r;
    logic [MEM_LATENCY:1]   valid_r;
    logic [MEM_LATENCY:1]   kill_r;
    logic [MEM_LATENCY:1]   err_r;
    logic [31:0]            rdata_hold_r;
    logic                   err_hold_r;

    assign offset_s    = instr_addr_i - BASE_ADDR;
    assign word_addr_s = offset_s[ADDR_WIDTH+1:2];

`ifdef IMEM_ERR_CHECK_EN
    // BASE_ADDR is word aligned, so offset bits [1:0] equal address bits [1:0].
    // An address below BASE_ADDR wraps to a large offset and has upper bits set.
    assign bad_s = (offset_s[1:0] != 2'b00) |
                   (offset_s[31:ADDR_WIDTH+2] != {(30-ADDR_WIDTH){1'b0}});
`else
    logic unused_offset_bits_s;
    assign bad_s                = 1'b0;
    assign unused_offset_bits_s = ^{offset_s[31:ADDR_WIDTH+2], offset_s[1:0]};
`endif

    // The oldest entry leaves the last stage this cycle, even if it was killed.
    assign retire_s = valid_r[MEM_LATENCY];
    // Hold off grants while reset is asserted, so gnt reads 0 in reset.
    assign gnt_s    = rstn & instr_req_i & ((cnt_r != MAX_CNT) | retire_s);
    // A flush in the retire cycle also discards that response: it was granted earlier.
    assign rvalid_s = valid_r[MEM_LATENCY] & ~kill_r[MEM_LATENCY] & ~flush_i;

    assign instr_gnt_o    = gnt_s;
    assign instr_rvalid_o = rvalid_s;
    assign mem_en_o       = gnt_s & ~bad_s;
    assign mem_addr_o     = mem_en_o ? word_addr_s : mem_addr_r;

    // Outstanding-request counter and the held SRAM address
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r      <= 3'd0;
            mem_addr_r <= {ADDR_WIDTH{1'b0}};
        end else begin
            cnt_r <= cnt_r + {2'b00, gnt_s} - {2'b00, retire_s};
            if (mem_en_o) begin
                mem_addr_r <= word_addr_s;
            end
        end
    end

    // Shift {valid, kill, err} through the stages; a flush kills every in-flight entry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_r <= {MEM_LATENCY{1'b0}};
            kill_r  <= {MEM_LATENCY{1'b0}};
            err_r   <= {MEM_LATENCY{1'b0}};
        end else begin
            valid_r[1] <= gnt_s;
            kill_r[1]  <= 1'b0;
            err_r[1]   <= bad_s;
            for (int k = 2; k <= MEM_LATENCY; k++) begin
                valid_r[k] <= valid_r[k-1];
                kill_r[k]  <= kill_r[k-1] | flush_i;
                err_r[k]   <= err_r[k-1];
            end
        end
    end

    generate
        if (MEM_LATENCY == 1) begin : g_direct
            assign last_data_s = mem_rdata_i;
        end else begin : g_pipe
            logic [31:0] data_r [2:MEM_LATENCY];

            // Carry the SRAM word from stage 1 to the last stage
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    for (int k = 2; k <= MEM_LATENCY; k++) begin
                        data_r[k] <= 32'h0;
                    end
                end else begin
                    data_r[2] <= mem_rdata_i;
                    for (int k = 3; k <= MEM_LATENCY; k++) begin
                        data_r[k] <= data_r[k-1];
                    end
                end
            end

            assign last_data_s = data_r[MEM_LATENCY];
        end
    endgenerate

    // Present the retiring response; otherwise keep showing the previous one
    always_comb begin
        if (rvalid_s) begin
            instr_rdata_o = err_r[MEM_LATENCY] ? 32'h0 : last_data_s;
            instr_err_o   = err_r[MEM_LATENCY];
        end else begin
            instr_rdata_o = rdata_hold_r;
            instr_err_o   = err_hold_r;
        end
    end

    // Remember the last presented response so it holds while rvalid is low
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_hold_r <= 32'h0;
            err_hold_r   <= 1'b0;
        end else begin
            rdata_hold_r <= instr_rdata_o;
            err_hold_r   <= instr_err_o;
        end
    end

endmodule
